pgm_gfx_ddr: RTL



---
 rtl/pgm_gfx_ddr.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pgm_gfx_ddr.sv
// pgm_gfx_ddr
// -----------
// Graphics-ROM read responder for the PGM video engine. It takes one 64-bit
// word read at a time from the video side and turns it into a single-beat
// Avalon-MM read on the MiSTer DDR3 port. The request address is relative to
// the graphics region; BASE_ADDR is added (29-bit, wrapping) to form the DDR
// word address. The returned word is held on ddram_dout until the next
// completion.
//
// Configuration macro: PGM_GFX_CACHE_EN
//   Defined   : a one-entry tag remembers the address of the last successful
//               fetch. A repeat request to that address completes with no
//               Avalon traffic and ddram_busy never rises. flush invalidates
//               the tag.
//   Undefined : every request is fetched; flush is ignored.
//
// Handshakes:
//   Video side : a request is taken on a rising edge where ddram_rd=1 and the
//                block is idle (ddram_busy=0). ddram_busy stays high until
//                ddram_dout holds the answer. ddram_addr is sampled only at
//                acceptance. Dropping ddram_rd mid-fetch does not cancel it.
//   Avalon side: avl_rd/avl_addr are held until a rising edge with
//                avl_waitrequest=0, which accepts the command. The data beat is
//                taken on the first edge with avl_dout_ready=1 while waiting;
//                beats outside the wait window are discarded. Only one read is
//                ever outstanding.
//
// Parameters:
//   BASE_ADDR : word offset of the graphics region in DDR.
//   TIMEOUT   : cycles to wait for read data before aborting (1..1023).
//
// Ports:
//   clk, reset       : single clock; asynchronous active-high reset.
//   ddram_rd         : read request from the video engine.
//   ddram_addr[28:0] : word address relative to the graphics region.
//   ddram_dout[63:0] : returned word (zero after a timeout).
//   ddram_busy       : fetch in progress.
//   flush            : invalidate the hit tag (cache build only).
//   avl_rd           : Avalon read strobe.
//   avl_addr[28:0]   : Avalon word address.
//   avl_burstcnt[7:0]: constant single-beat burst.
//   avl_waitrequest  : Avalon wait.
//   avl_dout[63:0]   : Avalon read data.
//   avl_dout_ready   : Avalon read-data valid.
//   err              : sticky read-timeout flag, cleared only by reset.

module pgm_gfx_ddr #(
  parameter logic [28:0] BASE_ADDR = 29'h0600000,
  parameter int          TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ddram_rd,
  input  logic [28:0] ddram_addr,
  output logic [63:0] ddram_dout,
  output logic        ddram_busy,
  input  logic        flush,
  output logic        avl_rd,
  output logic [28:0] avl_addr,
  output logic [7:0]  avl_burstcnt,
  input  logic        avl_waitrequest,
  input  logic [63:0] avl_dout,
  input  logic        avl_dout_ready,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Exposed by name so checkers can bind to the FSM state directly.
  state_t state;

  // The counter holds the number of WAIT edges already spent without data;
  // the abort happens on the TIMEOUT-th such edge.
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

  logic [9:0] wait_cnt;
  logic       hit;
  logic       miss_accept;
  logic       fetch_done;

  assign avl_burstcnt = 8'd1;

  assign miss_accept = (state == ST_IDLE) && ddram_rd && !hit;
  assign fetch_done  = (state == ST_WAIT) && avl_dout_ready;

`ifdef PGM_GFX_CACHE_EN
  logic        tag_valid;
  logic [28:0] tag_addr;
  logic [28:0] req_addr;

  // A flush in the same cycle as a matching request forces a real fetch.
  assign hit = tag_valid && (tag_addr == ddram_addr) && !flush;

  // The tag is cleared when a fetch starts (ddram_dout is about to change)
  // and set only when that fetch returns data, so a timeout leaves it empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= 1'b0;
      tag_addr  <= '0;
      req_addr  <= '0;
    end else begin
      if (miss_accept) begin
        req_addr  <= ddram_addr;
        tag_valid <= 1'b0;
      end
      if (fetch_done) begin
        tag_valid <= 1'b1;
        tag_addr  <= req_addr;
      end
      if (flush) begin
        tag_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_flush;

  assign hit          = 1'b0;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ddram_busy <= 1'b0;
      ddram_dout <= '0;
      avl_rd     <= 1'b0;
      avl_addr   <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Stale avl_dout_ready beats are ignored here.
          if (miss_accept) begin
            ddram_busy <= 1'b1;
            avl_rd     <= 1'b1;
            avl_addr   <= BASE_ADDR + ddram_addr;  // wraps modulo 2^29
            state      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // avl_rd is always high in this state; hold until accepted.
          if (!avl_waitrequest) begin
            avl_rd   <= 1'b0;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (avl_dout_ready) begin
            ddram_dout <= avl_dout;
            ddram_busy <= 1'b0;
            state      <= ST_IDLE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            ddram_dout <= '0;
            err        <= 1'b1;
            ddram_busy <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          ddram_busy <= 1'b0;
          avl_rd     <= 1'b0;
        end
      endcase
    end
  end

endmodule
